shifter_pipe: RTL and testbench
===============================

// Module: shifter_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter for the ALU/EX datapath. Replaces the single-cycle 16-bit shifter.
//  Adds SRL and ROL modes, a carry (last bit out) and a zero flag, a sideband tag, and valid/ready flow control.
//  One binary rank per register stage gives full throughput at higher fmax.
// PARAMETERS
//  WIDTH    16                    data width; power of two, >=4
//  SHAMT_W  $clog2(WIDTH)         shift-amount width (derived, do not override)
//  TAG_W    4                     sideband tag width, carried unmodified
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  flush      in   1        sync clear of all in-flight ops (ignored vs rst)
//  in_valid   in   1        input op valid
//  in_ready   out  1        unit can accept op this cycle
//  in_data    in   WIDTH    operand
//  in_shamt   in   SHAMT_W  shift amount 0..WIDTH-1
//  in_mode    in   3        0 NONE,1 SLL,2 SRL,3 SRA,4 ROR,5 ROL; 6,7 act as NONE
//  in_tag     in   TAG_W    sideband tag
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_data   out  WIDTH    shifted result
//  out_carry  out  1        last bit shifted out (see rules)
//  out_zero   out  1        out_data == 0
//  out_tag    out  TAG_W    tag of this result
// BEHAVIOUR
//  - Transfer on valid&ready at either port; out_* are stable while out_valid & !out_ready.
//  - SHAMT_W ranks; rank k shifts by 2^k when shamt[k]=1. Rank k output is registered in stage k.
//  - Stage k holds {valid,data,carry,shamt,mode,tag}.
//  - Latency: SHAMT_W cycles from accept to out_valid (4 for WIDTH=16), for every mode and amount.
//  - Per-stage advance: adv[k] = !v[k] | adv[k+1]; last stage adv = !v | out_ready.
//  - in_ready = adv[0]. One op per cycle when unstalled; no bubbles are inserted, none are required.
//  - SLL/SRL fill with 0; SRA fills with the MSB of the operand; ROR/ROL wrap.
//  - Carry on SLL: last bit out of the MSB. Carry on SRL/SRA: last bit out of the LSB.
//  - Carry on ROR: result MSB. Carry on ROL: result LSB.
//  - Carry is 0 for NONE, for shamt==0, and for modes 6 and 7.
//  - Carry is tracked per rank: a rank with shift 1 overwrites carry; a rank with shift 0 keeps it.
//  - out_zero is computed combinationally from the last-stage data.
//  - Reset: next cycle every valid=0, out_valid=0, out_data=0, out_carry=0, out_tag=0, out_zero=1.
//    in_ready=1 in the first cycle after reset.
//  - rst or flush mid-operation: all in-flight ops are dropped, none emerge.
//  - Same-cycle in_valid with flush: the op is not accepted (in_ready forced 0 while flush=1).
//  - No combinational path from in_* to out_*. The only combinational ready path is out_ready->in_ready.
// STRUCTURE
//  - shifter_pkg: mode localparams (MODE_NONE..MODE_ROL), helper function is_left(mode).
//  - Sub-module shift_rank #(WIDTH,DIST): one combinational rank.
//    I/O: data, carry, mode in -> data, carry out when en=1; passthrough when en=0.
//  - Top: generate loop of SHAMT_W shift_rank instances plus the stage registers and adv chain.
// TESTING (WIDTH=16, TAG_W=4)
//  1. Latency and SRA: 0x8000, SRA, 4, tag 3 -> 4 cycles later 0xF800, carry 0, zero 0, tag 3.
//  2. Left/right shifts: 0x8001 SLL 1 -> 0x0002, carry 1. 0x0001 SLL 15 -> 0x8000, carry 0.
//     0x0003 SRL 1 -> 0x0001, carry 1. 0x0001 SRL 1 -> 0x0000, carry 1, zero 1.
//  3. Rotates and NONE: 0x1234 ROR 4 -> 0x4123, carry 0. 0x1234 ROL 4 -> 0x2341, carry 1.
//     mode 7 on 0xABCD -> 0xABCD, carry 0.
//  4. Back-pressure: stream 8 ops with tags 0..7 and hold out_ready=0 for 6 cycles.
//     Expect exactly 4 accepted, then in_ready=0. After release: all 8 results in order,
//     none lost or duplicated, 1 per cycle.
//  5. Reset/flush: fill the pipe, assert rst 1 cycle -> out_valid=0 next cycle, no stale result later.
//     Repeat with flush plus a same-cycle in_valid -> that op is not accepted.
//  6. Random: 10k ops, random modes, amounts and stall patterns vs a reference model.
//     Check data, carry, zero, tag and ordering.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// small helpers that classify a mode as shifting and as leftward.
package shifter_pkg;

    localparam logic [2:0] MODE_NONE = 3'd0;
    localparam logic [2:0] MODE_SLL  = 3'd1;
    localparam logic [2:0] MODE_SRL  = 3'd2;
    localparam logic [2:0] MODE_SRA  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_ROL  = 3'd5;

    // Left-moving modes take their carry from the top of the word.
    function automatic logic is_left(input logic [2:0] mode);
        return (mode == MODE_SLL) || (mode == MODE_ROL);
    endfunction

    // Codes 6 and 7 are unused and behave exactly like NONE.
    function automatic logic is_shift(input logic [2:0] mode);
        return (mode >= MODE_SLL) && (mode <= MODE_ROL);
    endfunction

endpackage

// File: rtl/shifter_if.sv
// Operand/result handshake bundle of the shifter: the master side issues
// operations and accepts results, the slave side is the shifter itself.
interface shifter_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [2:0]         in_mode;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_carry;
    logic               out_zero;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_tag
    );

endinterface

// File: rtl/shift_rank.sv
// One combinational rank of the barrel shifter: moves the word by DIST bits
// when enabled, otherwise passes data and carry through unchanged.
module shift_rank
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
);

    // The bit leaving the word last in this rank is also the final carry
    // if no later rank shifts; for rotates it equals the new MSB/LSB.
    always_comb begin
        data_out  = data_in;
        carry_out = carry_in;
        if (en && is_shift(mode)) begin
            carry_out = is_left(mode) ? data_in[WIDTH-DIST] : data_in[DIST-1];
            case (mode)
                MODE_SLL: data_out = data_in << DIST;
                MODE_SRL: data_out = data_in >> DIST;
                MODE_SRA: data_out = $signed(data_in) >>> DIST;
                MODE_ROR: data_out = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
                MODE_ROL: data_out = {data_in[WIDTH-DIST-1:0], data_in[WIDTH-1:WIDTH-DIST]};
                default:  data_out = data_in;
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one binary rank per register stage, elastic
// valid/ready flow control, carry and zero flags, and a sideband tag.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    shifter_if.slave  bus
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LAST    = SHAMT_W - 1;

    logic               st_valid [SHAMT_W];
    logic [WIDTH-1:0]   st_data  [SHAMT_W];
    logic               st_carry [SHAMT_W];
    logic [SHAMT_W-1:0] st_shamt [SHAMT_W];
    logic [2:0]         st_mode  [SHAMT_W];
    logic [TAG_W-1:0]   st_tag   [SHAMT_W];

    logic               adv      [SHAMT_W];

    logic               rank_en        [SHAMT_W];
    logic [2:0]         rank_mode      [SHAMT_W];
    logic [WIDTH-1:0]   rank_data_in   [SHAMT_W];
    logic               rank_carry_in  [SHAMT_W];
    logic [WIDTH-1:0]   rank_data_out  [SHAMT_W];
    logic               rank_carry_out [SHAMT_W];

    // A stage may take new contents when it is empty or its occupant moves on;
    // out_ready ripples back to in_ready through this chain only.
    always_comb begin
        adv[LAST] = !st_valid[LAST] || bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = !st_valid[k] || adv[k+1];
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_rank
        if (k == 0) begin : g_first
            assign rank_en[k]       = bus.in_shamt[0];
            assign rank_mode[k]     = bus.in_mode;
            assign rank_data_in[k]  = bus.in_data;
            assign rank_carry_in[k] = 1'b0;
        end else begin : g_next
            assign rank_en[k]       = st_shamt[k-1][k];
            assign rank_mode[k]     = st_mode[k-1];
            assign rank_data_in[k]  = st_data[k-1];
            assign rank_carry_in[k] = st_carry[k-1];
        end

        shift_rank #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_rank (
            .en        (rank_en[k]),
            .mode      (rank_mode[k]),
            .data_in   (rank_data_in[k]),
            .carry_in  (rank_carry_in[k]),
            .data_out  (rank_data_out[k]),
            .carry_out (rank_carry_out[k])
        );
    end

    // Stage k registers the output of rank k; flush only kills valid bits
    // because payload of an invalid stage is never observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                st_valid[k] <= 1'b0;
                st_data[k]  <= '0;
                st_carry[k] <= 1'b0;
                st_shamt[k] <= '0;
                st_mode[k]  <= MODE_NONE;
                st_tag[k]   <= '0;
            end
        end else begin
            if (adv[0]) begin
                st_valid[0] <= bus.in_valid;
                st_data[0]  <= rank_data_out[0];
                st_carry[0] <= rank_carry_out[0];
                st_shamt[0] <= bus.in_shamt;
                st_mode[0]  <= bus.in_mode;
                st_tag[0]   <= bus.in_tag;
            end
            for (int k = 1; k < SHAMT_W; k++) begin
                if (adv[k]) begin
                    st_valid[k] <= st_valid[k-1];
                    st_data[k]  <= rank_data_out[k];
                    st_carry[k] <= rank_carry_out[k];
                    st_shamt[k] <= st_shamt[k-1];
                    st_mode[k]  <= st_mode[k-1];
                    st_tag[k]   <= st_tag[k-1];
                end
            end
            if (flush) begin
                for (int k = 0; k < SHAMT_W; k++) begin
                    st_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = adv[0] && !flush;
    assign bus.out_valid = st_valid[LAST];
    assign bus.out_data  = st_data[LAST];
    assign bus.out_carry = st_carry[LAST];
    assign bus.out_tag   = st_tag[LAST];
    assign bus.out_zero  = (st_data[LAST] == '0);

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: accepted ops push expected results,
// a negedge monitor pops and compares every result the DUT hands over.
module tb_shifter_pipe;
    import shifter_pkg::*;

    localparam int WIDTH   = 16;
    localparam int TAG_W   = 4;
    localparam int LATENCY = 4;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    shifter_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t cur_exp;
    int   checks    = 0;
    int   errors    = 0;
    int   out_count = 0;
    int   accepted  = 0;
    bit   last_taken = 0;
    bit   rand_mode  = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference works on the whole shift amount at once using a doubled word.
    task automatic refShift(input logic [15:0] d, input logic [3:0] n, input logic [2:0] m,
                            output logic [15:0] r, output logic c);
        logic [31:0] dd;
        int amt;
        dd  = {d, d};
        amt = int'(n);
        r   = d;
        c   = 1'b0;
        case (m)
            3'd1: begin r = d << amt; c = (amt != 0) ? d[16-amt] : 1'b0; end
            3'd2: begin r = d >> amt; c = (amt != 0) ? d[amt-1]  : 1'b0; end
            3'd3: begin r = $signed(d) >>> amt; c = (amt != 0) ? d[amt-1] : 1'b0; end
            3'd4: begin dd = dd >> amt; r = dd[15:0];  c = (amt != 0) ? r[15] : 1'b0; end
            3'd5: begin dd = dd << amt; r = dd[31:16]; c = (amt != 0) ? r[0]  : 1'b0; end
            default: begin r = d; c = 1'b0; end
        endcase
    endtask

    task automatic loadOp(input logic [15:0] d, input logic [3:0] s, input logic [2:0] m,
                          input logic [3:0] t, input logic [15:0] ed, input logic ec);
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_mode  = m;
        bus.in_tag   = t;
        cur_exp      = '{data: ed, carry: ec, zero: (ed == 16'h0), tag: t};
        bus.in_valid = 1'b1;
    endtask

    // One clock: record an accepted op at negedge, drop the queue after a kill edge.
    task automatic tick();
        bit kill;
        @(negedge clk);
        kill = rst || flush;
        last_taken = 0;
        if (bus.in_valid && bus.in_ready && !kill) begin
            exp_q.push_back(cur_exp);
            accepted++;
            last_taken = 1;
        end
        @(posedge clk);
        if (kill) exp_q.delete();
        #1;
        if (last_taken) bus.in_valid = 1'b0;
        if (rand_mode) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 511) == 0);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] s, input logic [2:0] m,
                                 input logic [3:0] t, input logic [15:0] ed, input logic ec);
        loadOp(d, s, m, t, ed, ec);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (last_taken) return;
        end
        checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic applyRandom(input logic [3:0] t);
        logic [15:0] d, r;
        logic [3:0]  s;
        logic [2:0]  m;
        logic        c;
        d = 16'($urandom);
        s = 4'($urandom_range(0, 15));
        m = 3'($urandom_range(0, 7));
        refShift(d, s, m, r, c);
        if ($urandom_range(0, 3) == 0) tick();
        applyStimulus(d, s, m, t, r, c);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        repeat (2) tick();
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare each handed-over result, and check outputs hold under stall.
    logic        stall_prev = 1'b0;
    logic [15:0] held_data;
    logic        held_carry;
    logic [3:0]  held_tag;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("hold_data",  32'(bus.out_data),  32'(held_data));
                checkOutput("hold_carry", 32'(bus.out_carry), 32'(held_carry));
                checkOutput("hold_tag",   32'(bus.out_tag),   32'(held_tag));
            end
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out: got tag %0h data %0h expected no result",
                             bus.out_tag, bus.out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("out_data",  32'(bus.out_data),  32'(e.data));
                    checkOutput("out_carry", 32'(bus.out_carry), 32'(e.carry));
                    checkOutput("out_zero",  32'(bus.out_zero),  32'(e.zero));
                    checkOutput("out_tag",   32'(bus.out_tag),   32'(e.tag));
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready && !flush;
            held_data  = bus.out_data;
            held_carry = bus.out_carry;
            held_tag   = bus.out_tag;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int base_acc;
        int base_out;
        logic [15:0] bp_d [8];
        logic [15:0] bp_r [8];
        logic [3:0]  bp_s [8];
        logic [2:0]  bp_m [8];
        logic        bp_c [8];
        int next;

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0;
        bus.in_mode = MODE_NONE; bus.in_tag = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
        checkOutput("rst_out_carry", 32'(bus.out_carry), 32'd0);
        checkOutput("rst_out_tag",   32'(bus.out_tag),   32'd0);
        checkOutput("rst_out_zero",  32'(bus.out_zero),  32'd1);
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;

        // Directed latency and SRA fill.
        applyStimulus(16'h8000, 4'd4, MODE_SRA, 4'd3, 16'hF800, 1'b0);
        lat = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin lat = cyc; break; end
        end
        checkOutput("latency", 32'(lat), 32'(LATENCY));
        @(posedge clk); #1;

        applyStimulus(16'h8001, 4'd1,  MODE_SLL, 4'd1, 16'h0002, 1'b1);
        applyStimulus(16'h0001, 4'd15, MODE_SLL, 4'd2, 16'h8000, 1'b0);
        applyStimulus(16'h0003, 4'd1,  MODE_SRL, 4'd3, 16'h0001, 1'b1);
        applyStimulus(16'h0001, 4'd1,  MODE_SRL, 4'd4, 16'h0000, 1'b1);
        applyStimulus(16'h1234, 4'd4,  MODE_ROR, 4'd5, 16'h4123, 1'b0);
        applyStimulus(16'h1234, 4'd4,  MODE_ROL, 4'd6, 16'h2341, 1'b1);
        applyStimulus(16'hABCD, 4'd5,  3'd7,     4'd7, 16'hABCD, 1'b0);
        applyStimulus(16'h00F0, 4'd0,  MODE_SRA, 4'd8, 16'h00F0, 1'b0);
        drain();

        // Back-pressure: 8 ops against a stalled output for 6 cycles.
        for (int i = 0; i < 8; i++) begin
            bp_d[i] = 16'($urandom);
            bp_s[i] = 4'($urandom_range(0, 15));
            bp_m[i] = 3'($urandom_range(0, 7));
            refShift(bp_d[i], bp_s[i], bp_m[i], bp_r[i], bp_c[i]);
        end
        bus.out_ready = 1'b0;
        base_acc = accepted;
        next = 0;
        loadOp(bp_d[0], bp_s[0], bp_m[0], 4'd0, bp_r[0], bp_c[0]);
        repeat (6) begin
            tick();
            if (last_taken && next < 7) begin
                next++;
                loadOp(bp_d[next], bp_s[next], bp_m[next], 4'(next), bp_r[next], bp_c[next]);
            end
        end
        checkOutput("bp_accepted", 32'(accepted - base_acc), 32'd4);
        checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        base_out = out_count;
        repeat (8) begin
            tick();
            if (last_taken && next < 7) begin
                next++;
                loadOp(bp_d[next], bp_s[next], bp_m[next], 4'(next), bp_r[next], bp_c[next]);
            end
        end
        checkOutput("bp_rate", 32'(out_count - base_out), 32'd8);
        checkOutput("bp_total", 32'(accepted - base_acc), 32'd8);
        drain();

        // Reset with a full pipe: nothing in flight may emerge.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyRandom(4'(i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        base_out = out_count;
        bus.out_ready = 1'b1;
        repeat (8) tick();
        checkOutput("mid_rst_no_stale", 32'(out_count - base_out), 32'd0);

        // Flush with a same-cycle op that must be refused.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyRandom(4'(i + 4));
        loadOp(16'h5A5A, 4'd3, MODE_SLL, 4'd9, 16'hD2D0, 1'b0);
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        base_out = out_count;
        bus.out_ready = 1'b1;
        repeat (8) tick();
        checkOutput("flush_no_stale", 32'(out_count - base_out), 32'd0);

        // Random traffic with random stalls and occasional flushes.
        rand_mode = 1;
        for (int i = 0; i < 10000; i++) applyRandom(4'(i));
        rand_mode = 0;
        flush = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
